// File: rtl/countdown_timer_bcd.sv
// BCD mm:ss countdown timer. Loads a sanitised preset, counts down once per
// 1 Hz tick with a borrow chain across four BCD digits, pulses done on
// reaching 00:00 and then holds alarm for ALARM_LEN ticks.
module countdown_timer_bcd #(
  parameter int unsigned ALARM_LEN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

  state_e     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic [3:0] alarm_cnt_q, alarm_cnt_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       alarm_q, alarm_d;

  // Saturate a BCD digit at its largest legal value.
  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] max);
    return (v > max) ? max : v;
  endfunction

  logic [3:0] su_dec, st_dec, mu_dec, mt_dec;
  logic       b_su, b_st, b_mu;
  logic       dec_zero;
  logic       alarm_last;

  // One-second decrement with borrow chain su -> st -> mu -> mt.
  always_comb begin
    b_su     = (sec_q[3:0] == 4'd0);
    su_dec   = b_su ? 4'd9 : sec_q[3:0] - 4'd1;
    b_st     = b_su && (sec_q[7:4] == 4'd0);
    st_dec   = b_su ? ((sec_q[7:4] == 4'd0) ? 4'd5 : sec_q[7:4] - 4'd1) : sec_q[7:4];
    b_mu     = b_st && (min_q[3:0] == 4'd0);
    mu_dec   = b_st ? ((min_q[3:0] == 4'd0) ? 4'd9 : min_q[3:0] - 4'd1) : min_q[3:0];
    // RUN never holds 00:00, so the top digit cannot underflow here.
    mt_dec   = b_mu ? min_q[7:4] - 4'd1 : min_q[7:4];
    dec_zero = ({mt_dec, mu_dec, st_dec, su_dec} == 16'h0000);
    alarm_last = (alarm_cnt_q == 4'(ALARM_LEN - 1));
  end

  // Next-state: command priority clear > load > pause > start > tick.
  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;
    if (clear) begin
      state_d     = StIdle;
      min_d       = 8'h00;
      sec_d       = 8'h00;
      alarm_cnt_d = 4'd0;
    end else if (load) begin
      if (state_q == StIdle || state_q == StPause) begin
        min_d = {clamp(load_min[7:4], 4'd5), clamp(load_min[3:0], 4'd9)};
        sec_d = {clamp(load_sec[7:4], 4'd5), clamp(load_sec[3:0], 4'd9)};
      end
    end else if (pause) begin
      if (state_q == StRun) state_d = StPause;
    end else if (start) begin
      if ((state_q == StIdle || state_q == StPause) && ({min_q, sec_q} != 16'h0000)) begin
        state_d = StRun;
      end
    end else if (tick) begin
      if (state_q == StRun) begin
        min_d = {mt_dec, mu_dec};
        sec_d = {st_dec, su_dec};
        if (dec_zero) begin
          state_d     = StAlarm;
          done_d      = 1'b1;
          alarm_cnt_d = 4'd0;
        end
      end else if (state_q == StAlarm) begin
        if (alarm_last) begin
          state_d     = StIdle;
          alarm_cnt_d = 4'd0;
        end else begin
          alarm_cnt_d = alarm_cnt_q + 4'd1;
        end
      end
    end
    running_d = (state_d == StRun);
    alarm_d   = (state_d == StAlarm);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      alarm_cnt_q <= 4'd0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= running_d;
      done_q      <= done_d;
      alarm_q     <= alarm_d;
    end
  end

  assign min_bcd = min_q;
  assign sec_bcd = sec_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: directed scenarios plus random commands,
// compared every cycle against a model that keeps the count in plain seconds.
module tb_countdown_timer_bcd;

  localparam int AlarmLen = 5;
  localparam int MIdle = 0, MRun = 1, MPause = 2, MAlarm = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] load_min = 8'h00, load_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, done, alarm;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_st  = MIdle;
  int m_cnt = 0;
  int m_at  = 0;
  bit m_done = 1'b0;

  countdown_timer_bcd #(.ALARM_LEN(AlarmLen)) dut (
    .clk(clk), .reset(reset), .tick(tick), .clear(clear), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int digit_clamp(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".min"},     {24'h0, min_bcd}, {24'h0, to_bcd(m_cnt / 60)});
    check({tag, ".sec"},     {24'h0, sec_bcd}, {24'h0, to_bcd(m_cnt % 60)});
    check({tag, ".running"}, {31'h0, running}, {31'h0, m_st == MRun});
    check({tag, ".done"},    {31'h0, done},    {31'h0, m_done});
    check({tag, ".alarm"},   {31'h0, alarm},   {31'h0, m_st == MAlarm});
  endtask

  task automatic model_step(input bit c, l, input logic [7:0] lm, ls, input bit s, p, t);
    m_done = 1'b0;
    if (c) begin
      m_st = MIdle; m_cnt = 0; m_at = 0;
    end else if (l) begin
      if (m_st == MIdle || m_st == MPause)
        m_cnt = (digit_clamp(int'(lm[7:4]), 5) * 10 + digit_clamp(int'(lm[3:0]), 9)) * 60
              +  digit_clamp(int'(ls[7:4]), 5) * 10 + digit_clamp(int'(ls[3:0]), 9);
    end else if (p) begin
      if (m_st == MRun) m_st = MPause;
    end else if (s) begin
      if ((m_st == MIdle || m_st == MPause) && m_cnt != 0) m_st = MRun;
    end else if (t) begin
      if (m_st == MRun) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_st = MAlarm; m_done = 1'b1; m_at = 0;
        end
      end else if (m_st == MAlarm) begin
        m_at++;
        if (m_at == AlarmLen) begin
          m_st = MIdle; m_at = 0;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit c, l, input logic [7:0] lm, ls,
                      input bit s, p, t);
    @(negedge clk);
    clear = c; load = l; load_min = lm; load_sec = ls; start = s; pause = p; tick = t;
    @(posedge clk);
    model_step(c, l, lm, ls, s, p, t);
    #1;
    check_model(tag);
  endtask

  task automatic do_tick(input string tag);
    step(tag, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_load(input string tag, input logic [7:0] lm, ls);
    step(tag, 1'b0, 1'b1, lm, ls, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start(input string tag);
    step(tag, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_clear(input string tag);
    step(tag, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1: one minute down to expiry.
    do_load("t1.load", 8'h01, 8'h00);
    do_start("t1.start");
    do_tick("t1.tick");
    check("t1.first", {16'h0, min_bcd, sec_bcd}, 32'h0059);
    for (int i = 0; i < 59; i++) do_tick("t1.run");
    check("t1.done", {31'h0, done}, 32'h1);
    check("t1.alarm", {31'h0, alarm}, 32'h1);
    step("t1.idle", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t1.done_pulse", {31'h0, done}, 32'h0);

    // 2: full borrow chain; load ignored in RUN.
    do_clear("t2.clear");
    do_load("t2.load", 8'h10, 8'h00);
    do_start("t2.start");
    do_tick("t2.tick");
    check("t2.borrow", {16'h0, min_bcd, sec_bcd}, 32'h0959);
    do_load("t2.load_run", 8'h33, 8'h33);

    // 3: pause wins over tick, ticks ignored in PAUSE, resume.
    do_clear("t3.clear");
    do_load("t3.load", 8'h00, 8'h30);
    do_start("t3.start");
    step("t3.pause_tick", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) do_tick("t3.paused");
    do_start("t3.resume");
    do_tick("t3.tick");
    check("t3.value", {16'h0, min_bcd, sec_bcd}, 32'h0029);

    // 4: sanitised load; start on zero does nothing.
    do_clear("t4.clear");
    do_load("t4.sanitise", 8'hAF, 8'h7C);
    check("t4.max", {16'h0, min_bcd, sec_bcd}, 32'h5959);
    do_load("t4.zero", 8'h00, 8'h00);
    do_start("t4.start_zero");
    check("t4.running", {31'h0, running}, 32'h0);

    // 5: alarm length, then clear during alarm.
    do_load("t5.load", 8'h00, 8'h01);
    do_start("t5.start");
    do_tick("t5.expire");
    for (int i = 0; i < AlarmLen; i++) do_tick("t5.alarm");
    check("t5.alarm_off", {31'h0, alarm}, 32'h0);
    do_load("t5.load2", 8'h00, 8'h01);
    do_start("t5.start2");
    do_tick("t5.expire2");
    do_tick("t5.alarm_tick1");
    step("t5.clear_tick2", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    // 6: async reset in RUN at 12:34.
    do_load("t6.load", 8'h12, 8'h34);
    do_start("t6.start");
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_st = MIdle; m_cnt = 0; m_at = 0; m_done = 1'b0;
    check_model("t6.async");
    #2;
    reset = 1'b0;
    do_tick("t6.after");

    // Random single-command traffic.
    do_clear("rnd.clear");
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) do_clear("rnd.clear");
      else if (r < 6) do_load("rnd.load_any", 8'($urandom), 8'($urandom));
      else if (r < 10) do_load("rnd.load_small", 8'h00, 8'($urandom_range(0, 8'h25)));
      else if (r < 14) step("rnd.pause", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      else if (r < 24) do_start("rnd.start");
      else if (r < 30) step("rnd.idle", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      else do_tick("rnd.tick");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
